countdown_setter: RTL and testbench
===================================

Name: countdown_setter

Overview:
- Front-end editor for the countdown timer, directly upstream of it.
- Turns five raw push-buttons into a packed BCD preset word and a run-enable level (`go`).
- The countdown loads the preset while `go`=0 and counts down while `go`=1.
- Tracks the countdown's `finish` flag so the user can acknowledge expiry and return to editing.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of clk cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz).
- HR10_MAX, 9, upper limit of the tens-of-hours digit.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- btn_up  input  1  raw button: increment the selected digit.
- btn_down  input  1  raw button: decrement the selected digit.
- btn_left  input  1  raw button: move cursor toward hr_10.
- btn_right  input  1  raw button: move cursor toward sec_1.
- btn_center  input  1  raw button: start / abort / acknowledge.
- finish  input  1  expiry flag from the countdown (slow-clock domain).
- preset  output  32  {hr_10,hr_1,4'hf,min_10,min_1,4'hf,sec_10,sec_1}, BCD digits.
- go  output  1  run enable to the countdown.
- cursor  output  3  selected digit: 0=sec_1, 1=sec_10, 2=min_1, 3=min_10, 4=hr_1, 5=hr_10.
- state_o  output  2  current state, for display blink logic.

Behaviour:
- **Reset (rst_n low, asynchronous):**
  - preset=32'h00f00f00, go=0, cursor=0, state=EDIT.
  - All debounce counters and synchronizers cleared.
- **Input conditioning:**
  - Every button and `finish` passes through a 2-FF synchronizer.
  - Each button is then filtered: the accepted level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any glitch restarts the count.
  - A press yields a one-cycle pulse on the accepted 0->1 edge. Release produces no pulse. Holding a button gives no auto-repeat.
  - Latency from a stable raw press to the pulse is DEBOUNCE_CYCLES+3 cycles. The register update happens on the following edge.
- **Simultaneous pulses:** priority center > up > down > left > right. Lower-priority pulses in the same cycle are dropped.
- **State EDIT (go=0):**
  - left: cursor+1, wrapping 5->0. right: cursor-1, wrapping 0->5.
  - up: selected digit +1, wrapping max->0. down: selected digit -1, wrapping 0->max.
  - Digit max values: sec_1=9, sec_10=5, min_1=9, min_10=5, hr_1=9, hr_10=HR10_MAX.
  - center with any nonzero digit: go to RUN and set go=1 on the same edge.
  - center with all digits zero: ignored, stay in EDIT.
- **State RUN (go=1):**
  - preset frozen; up/down/left/right ignored.
  - Synchronized finish rising edge: go to DONE.
  - center: abort to EDIT with go=0. preset retains the last edited value, so the countdown reloads it.
  - If center and the finish edge occur in the same cycle, center wins (go to EDIT).
- **State DONE (go=1):**
  - go held at 1 so the countdown keeps finish asserted.
  - center: go to EDIT with go=0; preset and cursor unchanged.
  - Other buttons ignored.
- **Fixed fields and decoding:**
  - Filler nibbles preset[11:8] and preset[23:20] are constant 4'hf in every state.
  - Illegal state encoding recovers to EDIT with go=0.
- **Invariants:**
  - preset never changes while go=1.
  - No digit ever exceeds its max, so the countdown always receives legal BCD.

Decomposition:
- Package countdown_pkg holds:
  - state encoding: EDIT=0, RUN=1, DONE=2;
  - digit index constants SEC1..HR10;
  - per-digit max constants;
  - FILL nibble 4'hf;
  - PRESET_RESET value 32'h00f00f00.
- Sub-module btn_debounce (synchronizer, stable counter and rising-edge pulse), instantiated five times.
- The top level holds the FSM, cursor, and digit registers.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- **Reset then edit:** reset, then btn_up x3 -> preset=32'h00f00f03, cursor=0, go=0.
- **Digit wrap:** move cursor to 1, then btn_up x6 -> sec_10 wraps 5->0, preset=32'h00f00f00. Then btn_down x1 -> preset=32'h00f00f50.
- **Cursor wrap and top digit:** btn_right from cursor 0 -> cursor 5. Then btn_down -> hr_10=9, preset=32'h90f00f00.
- **Start rules:**
  - center with preset=32'h00f00f00 -> stays EDIT, go=0.
  - Set sec_1=5, then center -> go=1, state RUN. btn_up during RUN -> preset unchanged.
- **Expiry:** in RUN, pulse finish high -> state DONE after sync, go=1. Then center -> EDIT, go=0, preset still 32'h00f00f05.
- **Glitch and async reset:**
  - A 2-cycle btn_up glitch produces no change.
  - Asserting rst_n low mid-RUN -> go=0 immediately, preset=32'h00f00f00, state EDIT.

Source files
------------

// File: rtl/countdown_setter_pkg.sv
// Shared types and constants for the countdown preset editor.
package countdown_pkg;

    // Editor states; encoding is visible on state_o for display blink logic.
    typedef enum logic [1:0] {
        EDIT = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit positions, also the cursor encoding.
    localparam int unsigned SEC1       = 0;
    localparam int unsigned SEC10      = 1;
    localparam int unsigned MIN1       = 2;
    localparam int unsigned MIN10      = 3;
    localparam int unsigned HR1        = 4;
    localparam int unsigned HR10       = 5;
    localparam int unsigned NUM_DIGITS = 6;

    // Largest legal value of each digit (hr_10 is overridable at the top).
    localparam logic [3:0] MAX_SEC1  = 4'd9;
    localparam logic [3:0] MAX_SEC10 = 4'd5;
    localparam logic [3:0] MAX_MIN1  = 4'd9;
    localparam logic [3:0] MAX_MIN10 = 4'd5;
    localparam logic [3:0] MAX_HR1   = 4'd9;
    localparam logic [3:0] MAX_HR10  = 4'd9;

    // Separator nibble between the hh / mm / ss fields.
    localparam logic [3:0]  FILL         = 4'hf;
    localparam logic [31:0] PRESET_RESET = 32'h00f00f00;

endpackage

// File: rtl/countdown_setter_if.sv
// Button / countdown-facing signal bundle of the preset editor.
interface countdown_setter_if;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_center;
    logic        finish;
    logic [31:0] preset;
    logic        go;
    logic [2:0]  cursor;
    logic [1:0]  state_o;

    // Driver side: buttons and the countdown's expiry flag.
    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_center, finish,
        input  preset, go, cursor, state_o
    );

    // Editor side.
    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_center, finish,
        output preset, go, cursor, state_o
    );
endinterface

// File: rtl/btn_debounce.sv
// Synchronizes one raw push-button, filters it for DEBOUNCE_CYCLES stable
// cycles and emits a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Synchronize, count consecutive disagreeing cycles, accept, edge-detect.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            // Any return to the accepted level restarts the stability count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end
endmodule

// File: rtl/countdown_setter.sv
// Preset editor for the countdown: debounced buttons edit six BCD digits,
// center starts / aborts / acknowledges, go enables the countdown.
module countdown_setter
    import countdown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HR10_MAX        = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    countdown_setter_if.slave  bus
);
    logic [4:0] raw_btn;
    logic [4:0] btn_pulse;
    logic       p_center, p_up, p_down, p_left, p_right;

    logic       finish_s1, finish_s2, finish_s3;
    logic       finish_rise;

    state_t     state;
    logic       go_q;
    logic [2:0] cursor_q;
    logic [3:0] digit [NUM_DIGITS];
    logic       any_nonzero;

    assign raw_btn = {bus.btn_center, bus.btn_up, bus.btn_down,
                      bus.btn_left, bus.btn_right};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_btn[i]),
            .pulse (btn_pulse[i])
        );
    end

    assign {p_center, p_up, p_down, p_left, p_right} = btn_pulse;

    // Bring the slow-domain finish flag in and detect its rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish_s1 <= 1'b0;
            finish_s2 <= 1'b0;
            finish_s3 <= 1'b0;
        end else begin
            finish_s1 <= bus.finish;
            finish_s2 <= finish_s1;
            finish_s3 <= finish_s2;
        end
    end

    assign finish_rise = finish_s2 & ~finish_s3;

    function automatic logic [3:0] digit_max(input logic [2:0] idx);
        case (idx)
            3'(SEC1):  return MAX_SEC1;
            3'(SEC10): return MAX_SEC10;
            3'(MIN1):  return MAX_MIN1;
            3'(MIN10): return MAX_MIN10;
            3'(HR1):   return MAX_HR1;
            default:   return 4'(HR10_MAX);
        endcase
    endfunction

    // Start is only allowed with a nonzero preset.
    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        any_nonzero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            any_nonzero = any_nonzero | (digit[i] != 4'd0);
        end
    end

    // Editor FSM with cursor and digit registers; button priority is
    // center > up > down > left > right.
    // NOTE: the six-entry digit array is reset explicitly; it is register
    // state the countdown reads, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EDIT;
            go_q     <= 1'b0;
            cursor_q <= 3'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit[i] <= 4'd0;
            end
        end else begin
            case (state)
                EDIT: begin
                    if (p_center) begin
                        if (any_nonzero) begin
                            state <= RUN;
                            go_q  <= 1'b1;
                        end
                    end else if (p_up) begin
                        digit[cursor_q] <= (digit[cursor_q] == digit_max(cursor_q))
                                           ? 4'd0 : digit[cursor_q] + 4'd1;
                    end else if (p_down) begin
                        digit[cursor_q] <= (digit[cursor_q] == 4'd0)
                                           ? digit_max(cursor_q) : digit[cursor_q] - 4'd1;
                    end else if (p_left) begin
                        cursor_q <= (cursor_q == 3'(HR10)) ? 3'd0 : cursor_q + 3'd1;
                    end else if (p_right) begin
                        cursor_q <= (cursor_q == 3'd0) ? 3'(HR10) : cursor_q - 3'd1;
                    end
                end
                RUN: begin
                    if (p_center) begin
                        state <= EDIT;
                        go_q  <= 1'b0;
                    end else if (finish_rise) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (p_center) begin
                        state <= EDIT;
                        go_q  <= 1'b0;
                    end
                end
                default: begin
                    state <= EDIT;
                    go_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.preset  = {digit[HR10], digit[HR1], FILL,
                          digit[MIN10], digit[MIN1], FILL,
                          digit[SEC10], digit[SEC1]};
    assign bus.go      = go_q;
    assign bus.cursor  = cursor_q;
    assign bus.state_o = state;
endmodule

// File: tb/tb_countdown_setter.sv
// Self-checking bench for countdown_setter with a short debounce window.
module tb_countdown_setter;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    countdown_setter_if bus ();

    countdown_setter #(.DEBOUNCE_CYCLES(DEB), .HR10_MAX(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: digits as plain integers, states 0=edit 1=run 2=done.
    int m_digit [6];
    int m_max   [6] = '{9, 5, 9, 5, 9, 9};
    int m_cursor;
    int m_state;

    function automatic logic [31:0] m_preset();
        return 32'((m_digit[5] << 28) | (m_digit[4] << 24) | (15 << 20) |
                   (m_digit[3] << 16) | (m_digit[2] << 12) | (15 << 8) |
                   (m_digit[1] << 4)  |  m_digit[0]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_digit[i] = 0;
        m_cursor = 0;
        m_state  = 0;
    endtask

    // Mask bits: 4=center 3=up 2=down 1=left 0=right; highest bit wins.
    task automatic model_press(input logic [4:0] mask);
        int sum;
        sum = 0;
        for (int i = 0; i < 6; i++) sum += m_digit[i];
        if (mask[4]) begin
            if (m_state == 0) m_state = (sum != 0) ? 1 : 0;
            else              m_state = 0;
        end else if (m_state == 0) begin
            if (mask[3])      m_digit[m_cursor] = (m_digit[m_cursor] + 1) % (m_max[m_cursor] + 1);
            else if (mask[2]) m_digit[m_cursor] = (m_digit[m_cursor] + m_max[m_cursor]) % (m_max[m_cursor] + 1);
            else if (mask[1]) m_cursor = (m_cursor + 1) % 6;
            else if (mask[0]) m_cursor = (m_cursor + 5) % 6;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".preset"}, bus.preset, m_preset());
        check({tag, ".go"},     32'(bus.go), 32'(m_state != 0));
        check({tag, ".cursor"}, 32'(bus.cursor), 32'(m_cursor));
        check({tag, ".state"},  32'(bus.state_o), 32'(m_state));
    endtask

    task automatic set_btns(input logic [4:0] mask);
        {bus.btn_center, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = mask;
    endtask

    task automatic press(input logic [4:0] mask);
        @(negedge clk);
        set_btns(mask);
        repeat (DEB + 6) @(negedge clk);
        set_btns(5'b0);
        repeat (DEB + 6) @(negedge clk);
        model_press(mask);
    endtask

    task automatic pulse_finish();
        @(negedge clk);
        bus.finish = 1'b1;
        repeat (8) @(negedge clk);
        bus.finish = 1'b0;
        repeat (4) @(negedge clk);
        if (m_state == 1) m_state = 2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    localparam logic [4:0] B_CENTER = 5'b10000;
    localparam logic [4:0] B_UP     = 5'b01000;
    localparam logic [4:0] B_DOWN   = 5'b00100;
    localparam logic [4:0] B_LEFT   = 5'b00010;
    localparam logic [4:0] B_RIGHT  = 5'b00001;

    // Hard stop in case stimulus ever stalls.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_btns(5'b0);
        bus.finish = 1'b0;
        model_reset();

        // Reset then edit.
        do_reset();
        check_all("reset");
        check("reset.preset_const", bus.preset, 32'h00f00f00);
        repeat (3) press(B_UP);
        check_all("up3");
        check("up3.preset_const", bus.preset, 32'h00f00f03);

        // Digit wrap on sec_10.
        do_reset();
        press(B_LEFT);
        repeat (6) press(B_UP);
        check_all("sec10_wrap");
        check("sec10_wrap.preset_const", bus.preset, 32'h00f00f00);
        press(B_DOWN);
        check("sec10_down.preset_const", bus.preset, 32'h00f00f50);

        // Cursor wrap 0 -> 5 and hr_10 down-wrap.
        do_reset();
        press(B_RIGHT);
        check("cursor_wrap", 32'(bus.cursor), 32'd5);
        press(B_DOWN);
        check_all("hr10_down");
        check("hr10_down.preset_const", bus.preset, 32'h90f00f00);

        // Start rules.
        do_reset();
        press(B_CENTER);
        check_all("start_zero");
        check("start_zero.go_const", 32'(bus.go), 32'd0);
        repeat (5) press(B_UP);
        press(B_CENTER);
        check_all("start_run");
        check("start_run.state_const", 32'(bus.state_o), 32'd1);
        press(B_UP);
        check_all("run_up_ignored");
        check("run_up_ignored.preset_const", bus.preset, 32'h00f00f05);

        // Expiry and acknowledge.
        pulse_finish();
        check_all("expiry");
        check("expiry.state_const", 32'(bus.state_o), 32'd2);
        press(B_CENTER);
        check_all("ack");
        check("ack.preset_const", bus.preset, 32'h00f00f05);

        // A 2-cycle glitch on up must not be accepted.
        @(negedge clk);
        bus.btn_up = 1'b1;
        repeat (2) @(negedge clk);
        bus.btn_up = 1'b0;
        repeat (DEB + 8) @(negedge clk);
        check_all("glitch");

        // Simultaneous up+left: only up takes effect.
        press(B_UP | B_LEFT);
        check_all("priority");
        check("priority.preset_const", bus.preset, 32'h00f00f06);

        // Abort from RUN keeps the edited preset.
        press(B_CENTER);
        press(B_CENTER);
        check_all("abort");

        // Randomized mix of buttons and finish pulses against the model.
        for (int n = 0; n < 40; n++) begin
            int op;
            op = int'($urandom_range(0, 5));
            if (op == 5) pulse_finish();
            else         press(5'(1 << op));
            check_all($sformatf("rand%0d", n));
        end

        // Asynchronous reset in the middle of RUN.
        if (m_state != 0) press(B_CENTER);
        if (m_preset() == 32'h00f00f00) press(B_UP);
        press(B_CENTER);
        check_all("pre_async");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        check("async_reset.go_const", 32'(bus.go), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
